// File: rtl/top.sv
`default_nettype none
// top: non-pipelined 8-bit von Neumann core (VEC/FETCH/IMM/EXEC/HALT), 256x8 memory, R0-R3.
// Optional feature macro: INTERRUPT_EN (level interrupt with PC/CCR shadow and RTI).

module top_memory (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] Mem [0:255];

  assign rdata = Mem[addr];

  always_ff @(posedge clk) begin
    if (we) Mem[addr] <= wdata;
  end
endmodule

module top_regfile (
  input  logic       clk,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] ra_addr,
  input  logic [1:0] rb_addr,
  output logic [7:0] ra_data,
  output logic [7:0] rb_data
);
  logic [7:0] file [0:3];

  assign ra_data = file[ra_addr];
  assign rb_data = file[rb_addr];

  always_ff @(posedge clk) begin
    if (we) file[waddr] <= wdata;
  end
endmodule

module top (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] In_port,
  input  logic       int_req,  // interrupt request; "int" is a reserved word
  output logic [7:0] Out_port,
  output logic       HLT
);
  typedef enum logic [2:0] {S_VEC, S_FETCH, S_IMM, S_EXEC, S_HALT} state_t;

  state_t     state_q, state_d;
  logic [7:0] PC, pc_d;
  logic [3:0] CCR_out, ccr_d;
  logic [7:0] ir_q, ir_d, opr_q, opr_d, out_q, out_d;
  logic       hlt_q, hlt_d;
  logic [3:0] op;
  logic [1:0] ra, rb;
  logic [7:0] ra_val, rb_val, mem_rdata, mem_addr, mem_wdata, rf_wdata;
  logic       mem_we, rf_we, branch, int_take;
  logic [1:0] rf_waddr;
  logic [9:0] alu;  // {V, C, result}

  assign op       = ir_q[7:4];
  assign ra       = ir_q[3:2];
  assign rb       = ir_q[1:0];
  assign Out_port = out_q;
  assign HLT      = hlt_q;

`ifdef INTERRUPT_EN
  logic       in_svc_q, in_svc_d;
  logic [7:0] spc_q, spc_d;
  logic [3:0] sccr_q, sccr_d;
  assign int_take = (state_q == S_FETCH) && int_req && !in_svc_q;
`else
  logic unused_int;
  assign unused_int = int_req;
  assign int_take   = 1'b0;
`endif

  top_memory u_Memory (
    .clk(clk), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata), .rdata(mem_rdata)
  );

  top_regfile regFile (
    .clk(clk), .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
    .ra_addr(ra), .rb_addr(rb), .ra_data(ra_val), .rb_data(rb_val)
  );

  function automatic logic [9:0] f_add(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y};
    return {(x[7] == y[7]) && (s[7] != x[7]), s[8], s[7:0]};
  endfunction

  // Carry bit of the result is the borrow out.
  function automatic logic [9:0] f_sub(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} - {1'b0, y};
    return {(x[7] != y[7]) && (s[7] != x[7]), s[8], s[7:0]};
  endfunction

  always_comb begin
    state_d   = state_q;
    pc_d      = PC;
    ccr_d     = CCR_out;
    ir_d      = ir_q;
    opr_d     = opr_q;
    out_d     = out_q;
    hlt_d     = hlt_q;
    mem_addr  = PC;
    mem_we    = 1'b0;
    mem_wdata = ra_val;
    rf_we     = 1'b0;
    rf_waddr  = ra;
    rf_wdata  = 8'h00;
    alu       = 10'd0;
    branch    = 1'b0;
`ifdef INTERRUPT_EN
    in_svc_d  = in_svc_q;
    spc_d     = spc_q;
    sccr_d    = sccr_q;
`endif
    case (state_q)
      S_VEC: begin
        mem_addr = 8'h00;
        pc_d     = mem_rdata;
        state_d  = S_FETCH;
      end
      S_FETCH: begin
        if (int_take) begin
          mem_addr = 8'h01;
          pc_d     = mem_rdata;
`ifdef INTERRUPT_EN
          in_svc_d = 1'b1;
          spc_d    = PC;
          sccr_d   = CCR_out;
`endif
        end else begin
          ir_d    = mem_rdata;
          pc_d    = PC + 8'd1;
          state_d = (mem_rdata[7:4] >= 4'h8 && mem_rdata[7:4] <= 4'hA) ? S_IMM : S_EXEC;
        end
      end
      S_IMM: begin
        opr_d   = mem_rdata;
        pc_d    = PC + 8'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          4'h1: begin rf_we = 1'b1; rf_wdata = rb_val; end
          4'h2, 4'h3: begin
            alu      = (op == 4'h2) ? f_add(ra_val, rb_val) : f_sub(ra_val, rb_val);
            rf_we    = 1'b1;
            rf_wdata = alu[7:0];
            ccr_d    = {alu[9:8], alu[7], alu[7:0] == 8'h00};
          end
          4'h4, 4'h5: begin
            rf_we    = 1'b1;
            rf_wdata = (op == 4'h4) ? (ra_val & rb_val) : (ra_val | rb_val);
            ccr_d    = {CCR_out[3:2], rf_wdata[7], rf_wdata == 8'h00};
          end
          4'h6: begin
            // NOT carries V/C through so one flag expression covers all four.
            case (ra)
              2'd0:    alu = f_add(rb_val, 8'h01);
              2'd1:    alu = f_sub(rb_val, 8'h01);
              2'd2:    alu = {CCR_out[3:2], ~rb_val};
              default: alu = f_sub(8'h00, rb_val);
            endcase
            rf_we    = 1'b1;
            rf_waddr = rb;
            rf_wdata = alu[7:0];
            ccr_d    = {alu[9:8], alu[7], alu[7:0] == 8'h00};
          end
          4'h7: begin
            if (ra == 2'd0) begin
              out_d = rb_val;
            end else if (ra == 2'd1) begin
              rf_we    = 1'b1;
              rf_waddr = rb;
              rf_wdata = In_port;
            end
          end
          4'h8: begin rf_we = 1'b1; rf_wdata = opr_q; end
          4'h9: begin mem_addr = opr_q; rf_we = 1'b1; rf_wdata = mem_rdata; end
          4'hA: begin mem_addr = opr_q; mem_we = 1'b1; end
          4'hB: begin mem_addr = rb_val; rf_we = 1'b1; rf_wdata = mem_rdata; end
          4'hC: begin mem_addr = rb_val; mem_we = 1'b1; end
          4'hD: begin
            branch = (ra == 2'd3) ? 1'b1 : CCR_out[ra];
            if (branch) begin
              pc_d = rb_val;
              if (ra != 2'd3) ccr_d[ra] = 1'b0;
            end
          end
          4'hE: begin
`ifdef INTERRUPT_EN
            if (ra == 2'd0) begin
              pc_d     = spc_q;
              ccr_d    = sccr_q;
              in_svc_d = 1'b0;
            end
`endif
          end
          4'hF: begin hlt_d = 1'b1; state_d = S_HALT; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_VEC;
      PC      <= 8'h00;
      CCR_out <= 4'h0;
      ir_q    <= 8'h00;
      opr_q   <= 8'h00;
      out_q   <= 8'h00;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      PC      <= pc_d;
      CCR_out <= ccr_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
      out_q   <= out_d;
      hlt_q   <= hlt_d;
    end
  end

`ifdef INTERRUPT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_svc_q <= 1'b0;
      spc_q    <= 8'h00;
      sccr_q   <= 4'h0;
    end else begin
      in_svc_q <= in_svc_d;
      spc_q    <= spc_d;
      sccr_q   <= sccr_d;
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// tb_top: scoreboard bench for the multi-cycle core; per-program expectations are queued
// when the program is loaded and drained against the DUT once it halts.
module tb_top;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       int_req = 1'b0;
  logic [7:0] In_port = 8'h00;
  logic [7:0] Out_port;
  logic       HLT;

  always #5 clk = ~clk;

  top dut (
    .clk(clk), .rst(rst), .In_port(In_port), .int_req(int_req),
    .Out_port(Out_port), .HLT(HLT)
  );

  typedef enum int {K_REG, K_MEM, K_PC, K_CCR, K_OUT, K_HLT} kind_t;
  typedef struct {
    string      tag;
    kind_t      kind;
    logic [7:0] idx;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pg[$];
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input kind_t k, input logic [7:0] idx, input logic [7:0] e);
    exp_t x;
    x.tag = tag; x.kind = k; x.idx = idx; x.exp = e;
    sb.push_back(x);
  endtask

  function automatic logic [7:0] observe(input kind_t k, input logic [7:0] idx);
    case (k)
      K_REG:   return dut.regFile.file[idx[1:0]];
      K_MEM:   return dut.u_Memory.Mem[idx];
      K_PC:    return dut.PC;
      K_CCR:   return {4'h0, dut.CCR_out};
      K_OUT:   return Out_port;
      default: return {7'h00, HLT};
    endcase
  endfunction

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk(x.tag, observe(x.kind, x.idx), x.exp);
    end
  endtask

  // Hold reset, backdoor-load memory (vector + program pg at base) and optionally
  // the register file, then release reset on a falling edge.
  task automatic setup(input logic [7:0] base, input bit load_regs,
                       input logic [7:0] r0, input logic [7:0] r1,
                       input logic [7:0] r2, input logic [7:0] r3);
    @(negedge clk);
    rst = 1'b1;
    int_req = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = i[7:0];
      dut.u_Memory.Mem[a] <= 8'h00;
    end
    dut.u_Memory.Mem[0] <= base;
    foreach (pg[i]) begin
      logic [7:0] a;
      a = base + i[7:0];
      dut.u_Memory.Mem[a] <= pg[i];
    end
    if (load_regs) begin
      dut.regFile.file[0] <= r0;
      dut.regFile.file[1] <= r1;
      dut.regFile.file[2] <= r2;
      dut.regFile.file[3] <= r3;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (HLT !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halted"}, {7'h00, HLT}, 8'h01);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // IN then OUT: Out_port changes exactly at the OUT execute edge.
    In_port = 8'hA5;
    pg = '{8'h74, 8'h70, 8'hF0};
    setup(8'h10, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    chk("out_before_exec", Out_port, 8'h00);
    @(negedge clk);
    chk("out_at_exec", Out_port, 8'hA5);
    run_to_halt("inout", 100);
    push("in_r0", K_REG, 8'd0, 8'hA5);
    push("inout_pc", K_PC, 8'd0, 8'h13);
    drain();

    // Asynchronous reset mid-cycle, then vector load one edge after release.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    push("rst_pc", K_PC, 8'd0, 8'h00);
    push("rst_out", K_OUT, 8'd0, 8'h00);
    push("rst_hlt", K_HLT, 8'd0, 8'h00);
    push("rst_ccr", K_CCR, 8'd0, 8'h00);
    drain();
    dut.u_Memory.Mem[0] <= 8'h02;
    dut.u_Memory.Mem[2] <= 8'hF0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("vec_pc", dut.PC, 8'h02);
    @(negedge clk);
    chk("fetch_pc", dut.PC, 8'h03);
    run_to_halt("vec", 20);

    // ADD signed overflow, then SUB to zero with registers kept across reset.
    pg = '{8'h26, 8'hF0};
    setup(8'h10, 1'b1, 8'h00, 8'h7F, 8'h01, 8'h00);
    run_to_halt("add", 100);
    push("add_r1", K_REG, 8'd1, 8'h80);
    push("add_ccr", K_CCR, 8'd0, 8'h0A);
    push("add_pc", K_PC, 8'd0, 8'h12);
    drain();
    pg = '{8'h35, 8'hF0};
    setup(8'h10, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    run_to_halt("sub", 100);
    push("sub_r1", K_REG, 8'd1, 8'h00);
    push("sub_ccr", K_CCR, 8'd0, 8'h01);
    push("keep_r2", K_REG, 8'd2, 8'h01);
    drain();

    // Conditional branches: JZ taken, JZ not taken, JC taken (clears only C).
    pg = '{8'h31, 8'hD2, 8'hF0};
    setup(8'h20, 1'b1, 8'h10, 8'h10, 8'h40, 8'h00);
    dut.u_Memory.Mem[8'h40] <= 8'hF0;
    run_to_halt("jz_t", 100);
    push("jz_t_pc", K_PC, 8'd0, 8'h41);
    push("jz_t_ccr", K_CCR, 8'd0, 8'h00);
    drain();
    setup(8'h20, 1'b1, 8'h10, 8'h0F, 8'h40, 8'h00);
    dut.u_Memory.Mem[8'h40] <= 8'hF0;
    run_to_halt("jz_n", 100);
    push("jz_n_pc", K_PC, 8'd0, 8'h23);
    push("jz_n_r0", K_REG, 8'd0, 8'h01);
    drain();
    pg = '{8'h31, 8'hDA, 8'hF0};
    setup(8'h20, 1'b1, 8'h00, 8'h01, 8'h40, 8'h00);
    dut.u_Memory.Mem[8'h40] <= 8'hF0;
    run_to_halt("jc_t", 100);
    push("jc_t_pc", K_PC, 8'd0, 8'h41);
    push("jc_t_ccr", K_CCR, 8'd0, 8'h02);
    push("jc_t_r0", K_REG, 8'd0, 8'hFF);
    drain();

    // Memory ops and logic/unary flags.
    pg = '{8'h80, 8'h3C, 8'hA0, 8'hE0, 8'h9C, 8'hE0, 8'h84, 8'hE0,
           8'hB9, 8'h6F, 8'h6A, 8'h43, 8'h52, 8'hC9, 8'hF0};
    setup(8'h10, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    run_to_halt("memlog", 200);
    push("ml_r0", K_REG, 8'd0, 8'hC7);
    push("ml_r2", K_REG, 8'd2, 8'hC3);
    push("ml_r3", K_REG, 8'd3, 8'hC4);
    push("ml_mem", K_MEM, 8'hE0, 8'hC3);
    push("ml_ccr", K_CCR, 8'd0, 8'h06);
    push("ml_pc", K_PC, 8'd0, 8'h1F);
    drain();

    // Interrupt: taken when enabled, ignored otherwise.
    pg = '{8'h84, 8'h7F, 8'h61, 8'h00, 8'h00, 8'hF0};
    setup(8'h10, 1'b1, 8'h00, 8'h00, 8'h55, 8'h00);
    dut.u_Memory.Mem[1]     <= 8'h80;
    dut.u_Memory.Mem[8'h80] <= 8'h3A;
    dut.u_Memory.Mem[8'h81] <= 8'hE0;
`ifdef INTERRUPT_EN
    begin
      int n;
      n = 0;
      while (dut.PC !== 8'h13 && n < 50) begin @(negedge clk); n++; end
      int_req = 1'b1;
      n = 0;
      while (dut.PC !== 8'h80 && n < 50) begin @(negedge clk); n++; end
      chk("irq_vector", dut.PC, 8'h80);
      int_req = 1'b0;
    end
    run_to_halt("irq", 200);
    push("irq_r2", K_REG, 8'd2, 8'h00);
`else
    int_req = 1'b1;
    run_to_halt("irq", 200);
    int_req = 1'b0;
    push("irq_r2", K_REG, 8'd2, 8'h55);
`endif
    push("irq_ccr", K_CCR, 8'd0, 8'h0A);
    push("irq_pc", K_PC, 8'd0, 8'h16);
    push("irq_r1", K_REG, 8'd1, 8'h80);
    drain();

    // Fibonacci into Mem[FF..F6], then verify state stays frozen after HLT.
    pg = '{8'h80, 8'h00, 8'h84, 8'h01, 8'h88, 8'hFF, 8'hC2, 8'h66,
           8'h1C, 8'h2D, 8'h11, 8'h17, 8'h8C, 8'hF5, 8'h3E, 8'h8C,
           8'h25, 8'hD3, 8'h8C, 8'h16, 8'hDF, 8'hF0};
    setup(8'h10, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    run_to_halt("fib", 3000);
    begin
      logic [7:0] fib [0:9];
      fib = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h05, 8'h08, 8'h0D, 8'h15, 8'h22};
      for (int k = 0; k < 10; k++) begin
        logic [7:0] a;
        a = 8'hFF - k[7:0];
        push($sformatf("fib%0d", k), K_MEM, a, fib[k]);
      end
    end
    push("fib_pc", K_PC, 8'd0, 8'h26);
    push("fib_ccr", K_CCR, 8'd0, 8'h00);
    push("fib_r0", K_REG, 8'd0, 8'h37);
    drain();
    int_req = 1'b1;
    In_port = 8'h3C;
    repeat (20) @(negedge clk);
    push("frz_pc", K_PC, 8'd0, 8'h26);
    push("frz_hlt", K_HLT, 8'd0, 8'h01);
    push("frz_out", K_OUT, 8'd0, 8'h00);
    push("frz_mem", K_MEM, 8'hF6, 8'h22);
    push("frz_r0", K_REG, 8'd0, 8'h37);
    drain();
    int_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
